// File: rtl/axis_3_to_1_arbiter_if.sv
// rtl/axis_3_to_1_arbiter_if.sv - AXI4-Stream bundle used for the arbiter's input and output ports
//
// Purpose: groups one AXI4-Stream channel (data, byte enables, sideband,
// valid/ready handshake and end-of-packet) so the arbiter can take whole
// channels as ports.
//
// Signals:
//   tdata  [TDATA_WIDTH]  beat data
//   tkeep  [TKEEP_WIDTH]  byte enables
//   tuser  [TUSER_WIDTH]  sideband
//   tvalid                beat valid (source to sink)
//   tready                sink ready (sink to source)
//   tlast                 end of packet
// Modports:
//   master  drives the channel (source side)
//   slave   receives the channel (sink side)

interface axis_3_to_1_arbiter_if #(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128
) ();

  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  logic [TDATA_WIDTH-1:0] tdata;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (
    output tdata,
    output tkeep,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tuser,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_3_to_1_arbiter.sv
// rtl/axis_3_to_1_arbiter.sv - packet-aware 3-input AXI4-Stream merge with round-robin arbitration
//
// Purpose: each input is buffered in a 16-entry fallthrough FIFO; whole
// packets are forwarded to the single output, never interleaving beats of
// different inputs. Arbitration happens only between packets.
//
// Ports:
//   axis_aclk     in   clock, all logic rising-edge
//   axis_resetn   in   asynchronous active-low reset
//   axis_input_0  slave  AXI4-Stream input 0
//   axis_input_1  slave  AXI4-Stream input 1
//   axis_input_2  slave  AXI4-Stream input 2
//   axis_output   master merged AXI4-Stream output
//
// Configuration macro:
//   AXIS_3_TO_1_ARBITER_FIXED_PRIORITY_EN
//     defined   : packet grant is fixed priority 0 > 1 > 2
//     undefined : round-robin starting after the last granted input

// First-word-fallthrough FIFO: dout always shows the oldest entry while
// empty is low, so a read strobe simply retires the word already on dout.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             nearly_full
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_COUNT        = (MAX_DEPTH_BITS + 1)'(DEPTH);
  // One free slot is kept in reserve: the upstream sees ready drop while a
  // final beat can still land.
  localparam logic [MAX_DEPTH_BITS:0] NEARLY_FULL_COUNT = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;
  logic                      do_wr;
  logic                      do_rd;

  assign empty       = (depth == '0);
  assign nearly_full = (depth >= NEARLY_FULL_COUNT);
  assign dout        = mem[rd_ptr];

  assign do_rd = rd_en & ~empty;
  // A write into a full FIFO is accepted only if a read frees a slot in the same cycle.
  assign do_wr = wr_en & ((depth != FULL_COUNT) | do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   depth <= depth + 1'b1;
        2'b01:   depth <= depth - 1'b1;
        default: depth <= depth;
      endcase
    end
  end

endmodule

module axis_3_to_1_arbiter #(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128
) (
  input  logic                         axis_aclk,
  input  logic                         axis_resetn,
  axis_3_to_1_arbiter_if.slave         axis_input_0,
  axis_3_to_1_arbiter_if.slave         axis_input_1,
  axis_3_to_1_arbiter_if.slave         axis_input_2,
  axis_3_to_1_arbiter_if.master        axis_output
);

  localparam int TKEEP_WIDTH    = TDATA_WIDTH / 8;
  localparam int FIFO_WIDTH     = TDATA_WIDTH + TKEEP_WIDTH + TUSER_WIDTH + 1;
  localparam int MAX_DEPTH_BITS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  logic                  fifo_reset;
  logic [FIFO_WIDTH-1:0] fifo_din  [3];
  logic [FIFO_WIDTH-1:0] fifo_dout [3];
  logic [2:0]            fifo_empty;
  logic [2:0]            fifo_nearly_full;
  logic [2:0]            fifo_wr;
  logic [2:0]            fifo_rd;
  logic [2:0]            in_valid;
  logic [2:0]            in_ready;

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            grant;
  logic [1:0]            grant_nxt;
  logic [1:0]            pick;
  logic                  out_valid;
  logic [FIFO_WIDTH-1:0] out_word;

`ifndef AXIS_3_TO_1_ARBITER_FIXED_PRIORITY_EN
  logic [1:0]            last_grant;
  logic [1:0]            last_grant_nxt;
`endif

  assign fifo_reset = ~axis_resetn;

  // Input side: beats go straight into the FIFOs, packed {tdata,tkeep,tuser,tlast}.
  assign fifo_din[0] = {axis_input_0.tdata, axis_input_0.tkeep, axis_input_0.tuser, axis_input_0.tlast};
  assign fifo_din[1] = {axis_input_1.tdata, axis_input_1.tkeep, axis_input_1.tuser, axis_input_1.tlast};
  assign fifo_din[2] = {axis_input_2.tdata, axis_input_2.tkeep, axis_input_2.tuser, axis_input_2.tlast};

  assign in_valid = {axis_input_2.tvalid, axis_input_1.tvalid, axis_input_0.tvalid};

  // Ready is forced low while reset is held so nothing is accepted into a FIFO being cleared.
  assign in_ready = ~fifo_nearly_full & {3{axis_resetn}};
  assign fifo_wr  = in_valid & in_ready;

  assign axis_input_0.tready = in_ready[0];
  assign axis_input_1.tready = in_ready[1];
  assign axis_input_2.tready = in_ready[2];

  for (genvar i = 0; i < 3; i++) begin : g_fifo
    fallthrough_small_fifo #(
      .WIDTH          (FIFO_WIDTH),
      .MAX_DEPTH_BITS (MAX_DEPTH_BITS)
    ) u_fifo (
      .clk         (axis_aclk),
      .reset       (fifo_reset),
      .din         (fifo_din[i]),
      .wr_en       (fifo_wr[i]),
      .rd_en       (fifo_rd[i]),
      .dout        (fifo_dout[i]),
      .empty       (fifo_empty[i]),
      .nearly_full (fifo_nearly_full[i])
    );
  end

  // Candidate for the next packet grant; only used when some FIFO is non-empty.
  always_comb begin
    pick = 2'd0;
`ifdef AXIS_3_TO_1_ARBITER_FIXED_PRIORITY_EN
    if (!fifo_empty[0]) begin
      pick = 2'd0;
    end else if (!fifo_empty[1]) begin
      pick = 2'd1;
    end else begin
      pick = 2'd2;
    end
`else
    // Scan last_grant+1, +2, +3 (mod 3): the previous winner has lowest priority.
    case (last_grant)
      2'd0: begin
        if (!fifo_empty[1])      pick = 2'd1;
        else if (!fifo_empty[2]) pick = 2'd2;
        else                     pick = 2'd0;
      end
      2'd1: begin
        if (!fifo_empty[2])      pick = 2'd2;
        else if (!fifo_empty[0]) pick = 2'd0;
        else                     pick = 2'd1;
      end
      default: begin
        if (!fifo_empty[0])      pick = 2'd0;
        else if (!fifo_empty[1]) pick = 2'd1;
        else                     pick = 2'd2;
      end
    endcase
`endif
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state      <= IDLE;
      grant      <= 2'd0;
`ifndef AXIS_3_TO_1_ARBITER_FIXED_PRIORITY_EN
      last_grant <= 2'd2;
`endif
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
`ifndef AXIS_3_TO_1_ARBITER_FIXED_PRIORITY_EN
      last_grant <= last_grant_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
`ifndef AXIS_3_TO_1_ARBITER_FIXED_PRIORITY_EN
    last_grant_nxt = last_grant;
`endif
    fifo_rd        = 3'b000;
    out_valid      = 1'b0;
    out_word       = '0;

    case (state)
      IDLE: begin
        if (fifo_empty != 3'b111) begin
          state_nxt      = SEND;
          grant_nxt      = pick;
`ifndef AXIS_3_TO_1_ARBITER_FIXED_PRIORITY_EN
          last_grant_nxt = pick;
`endif
        end
      end
      SEND: begin
        // The grant is held until the tlast beat leaves; an empty granted
        // FIFO mid-packet just stalls the output with tvalid low.
        out_word  = fifo_dout[grant];
        out_valid = ~fifo_empty[grant];
        if (out_valid && axis_output.tready) begin
          fifo_rd[grant] = 1'b1;
          if (out_word[0]) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign axis_output.tvalid = out_valid;
  assign axis_output.tdata  = out_word[FIFO_WIDTH-1 -: TDATA_WIDTH];
  assign axis_output.tkeep  = out_word[TUSER_WIDTH+1 +: TKEEP_WIDTH];
  assign axis_output.tuser  = out_word[1 +: TUSER_WIDTH];
  assign axis_output.tlast  = out_word[0];

endmodule
